dkong3_obj_dma: RTL and testbench
=================================

DKONG3_OBJ_DMA -- requirements
Module: dkong3_obj_dma

Interface
REQ-001 SHALL have parameter XFER_LEN, default 384, meaning the number of bytes copied per transfer (1..1024).
REQ-002 SHALL have parameter OBJ_BASE, default 10'h000, meaning the first object-RAM destination address.
REQ-003 SHALL have port I_CLK_24M, input, width 1: the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port I_RSTn, input, width 1: asynchronous, active-low reset.
REQ-005 SHALL have port I_CE, input, width 1: step enable; the FSM advances only on edges where I_CE=1.
REQ-006 SHALL have port I_START, input, width 1: one-clock transfer trigger (CPU write to the DMA register).
REQ-007 SHALL have port I_SRC_PAGE, input, width 8: source address high byte, latched at accepted start.
REQ-008 SHALL have port I_VBLK, input, width 1: vertical blank, active high.
REQ-009 SHALL have port O_BUSRQn, output, width 1: CPU bus request, active low.
REQ-010 SHALL have port I_BUSAKn, input, width 1: CPU bus acknowledge, active low.
REQ-011 SHALL have ports O_SRC_A (output, 16) and O_SRC_RDn (output, 1, active low): source read address and strobe.
REQ-012 SHALL have port I_SRC_D, input, width 8: source read data.
REQ-013 SHALL have ports O_OBJ_DMA_A (output, 10), O_OBJ_DMA_D (output, 8), O_OBJ_DMA_CE (output, 1): object-RAM write port.
REQ-014 SHALL have ports O_BUSY (output, 1) and O_DONE (output, 1, one-clock pulse).

Function
REQ-015 SHALL implement FSM states IDLE, WAIT_VBL, REQ, RD_ADDR, RD_DATA, WR, RELEASE.
REQ-016 IDLE: I_START=1 (sampled on any clock, independent of I_CE) -> latch I_SRC_PAGE, clear byte counter N, go to WAIT_VBL.
REQ-017 I_START while not IDLE SHALL be ignored: no relatch, no restart.
REQ-018 WAIT_VBL -> REQ on a CE edge with I_VBLK=1; otherwise hold.
REQ-019 REQ: O_BUSRQn=0; -> RD_ADDR on a CE edge with I_BUSAKn=0.
REQ-020 RD_ADDR: O_SRC_A={page,8'h00}+N (16-bit, wraps mod 65536); O_SRC_RDn=0; -> RD_DATA on next CE edge.
REQ-021 RD_DATA: address and O_SRC_RDn=0 held; I_SRC_D captured into data register on the CE edge that leaves the state; -> WR.
REQ-022 WR: O_OBJ_DMA_A=OBJ_BASE+N (10-bit, wraps mod 1024); O_OBJ_DMA_D=captured byte; O_OBJ_DMA_CE=1 for exactly the one clock of the CE edge leaving WR; O_SRC_RDn=1.
REQ-023 Leaving WR: N increments; if N+1=XFER_LEN -> RELEASE, else -> RD_ADDR.
REQ-024 Per-byte cost: exactly 3 CE steps; full default transfer = 1152 CE steps after grant.
REQ-025 If I_BUSAKn goes 1 while in RD_ADDR/RD_DATA/WR, FSM SHALL return to REQ at the next CE edge with N unchanged, then re-read the same byte after re-grant.
REQ-026 I_VBLK falling mid-transfer SHALL NOT abort; transfer completes.
REQ-027 RELEASE: O_BUSRQn=1; O_DONE=1 for one clock; -> IDLE on next CE edge.
REQ-028 O_BUSY=1 in every state except IDLE.
REQ-029 O_BUSRQn=0 only in REQ, RD_ADDR, RD_DATA, WR.
REQ-030 I_CE=0 SHALL freeze state, counter, and all outputs, except that O_OBJ_DMA_CE and O_DONE are 0.
REQ-031 Simultaneous I_START and RELEASE exit: start ignored (FSM not yet IDLE).

Reset
REQ-032 I_RSTn=0 SHALL immediately, asynchronously force: state IDLE, N=0, page=0, O_BUSRQn=1, O_SRC_RDn=1, O_SRC_A=0, O_OBJ_DMA_A=OBJ_BASE, O_OBJ_DMA_D=0, O_OBJ_DMA_CE=0, O_BUSY=0, O_DONE=0.
REQ-033 Reset mid-transfer SHALL abandon it with no further object-RAM write; the bus is released the same cycle.

Verification
REQ-034 Start page 8'h60, I_VBLK=1, BUSAKn granted 2 CE later -> 384 writes, dest 0x000..0x17F = src 0x6000..0x617F, O_DONE pulse, then O_BUSRQn=1.
REQ-035 Start with I_VBLK=0 for 50 CE, then 1 -> O_BUSRQn stays 1 for those 50 CE; request asserted on the first CE with I_VBLK=1.
REQ-036 Drop I_BUSAKn after byte 10 for 20 CE -> no write during the gap; byte 10 re-read from 0x600A; final RAM image identical to REQ-034.
REQ-037 I_START pulses at byte 100 with page 8'h70 -> ignored; all source addresses remain 0x60xx/0x61xx.
REQ-038 Assert I_RSTn=0 at byte 200 -> same clock: O_BUSRQn=1, O_BUSY=0, O_OBJ_DMA_CE=0; a later start restarts at N=0.
REQ-039 XFER_LEN=1024, OBJ_BASE=10'h200, page 8'hFF -> source wraps 0xFFFF->0x0000 and destination wraps 0x3FF->0x000; exactly 1024 writes.

Source files
------------

// File: rtl/dkong3_obj_dma.sv
// Object-RAM DMA: copies XFER_LEN bytes from a CPU-side page into object RAM
// during vertical blank, holding the CPU bus via BUSRQ/BUSAK for the copy.
module dkong3_obj_dma #(
    parameter int         XFER_LEN = 384,
    parameter logic [9:0] OBJ_BASE = 10'h000
) (
    input  logic        I_CLK_24M,
    input  logic        I_RSTn,
    input  logic        I_CE,
    input  logic        I_START,
    input  logic [7:0]  I_SRC_PAGE,
    input  logic        I_VBLK,
    output logic        O_BUSRQn,
    input  logic        I_BUSAKn,
    output logic [15:0] O_SRC_A,
    output logic        O_SRC_RDn,
    input  logic [7:0]  I_SRC_D,
    output logic [9:0]  O_OBJ_DMA_A,
    output logic [7:0]  O_OBJ_DMA_D,
    output logic        O_OBJ_DMA_CE,
    output logic        O_BUSY,
    output logic        O_DONE
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_VBL = 3'd1,
        REQ      = 3'd2,
        RD_ADDR  = 3'd3,
        RD_DATA  = 3'd4,
        WR       = 3'd5,
        RELEASE  = 3'd6
    } state_t;

    localparam logic [10:0] LAST_N = 11'(XFER_LEN - 1);

    state_t      state_r, state_nxt_s;
    logic [10:0] n_r, n_nxt_s;
    logic [7:0]  page_r, page_nxt_s;
    logic [7:0]  data_r, data_nxt_s;

    function automatic logic [15:0] src_addr(input logic [7:0] page, input logic [10:0] n);
        return {page, 8'h00} + {5'b00000, n};
    endfunction

    function automatic logic [9:0] obj_addr(input logic [10:0] n);
        return OBJ_BASE + n[9:0];
    endfunction

    // State, byte counter, page and data registers
    always_ff @(posedge I_CLK_24M or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state_r <= IDLE;
            n_r     <= 11'd0;
            page_r  <= 8'h00;
            data_r  <= 8'h00;
        end else begin
            state_r <= state_nxt_s;
            n_r     <= n_nxt_s;
            page_r  <= page_nxt_s;
            data_r  <= data_nxt_s;
        end
    end

    // Next-state logic; a lost grant in any bus phase falls back to REQ with N kept
    always_comb begin
        state_nxt_s = state_r;
        n_nxt_s     = n_r;
        page_nxt_s  = page_r;
        data_nxt_s  = data_r;
        case (state_r)
            IDLE: begin
                if (I_START) begin
                    page_nxt_s  = I_SRC_PAGE;
                    n_nxt_s     = 11'd0;
                    state_nxt_s = WAIT_VBL;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT_VBL: begin
                if (I_CE && I_VBLK) state_nxt_s = REQ;
                else                state_nxt_s = WAIT_VBL;
            end
            REQ: begin
                if (I_CE && !I_BUSAKn) state_nxt_s = RD_ADDR;
                else                   state_nxt_s = REQ;
            end
            RD_ADDR: begin
                if (!I_CE)         state_nxt_s = RD_ADDR;
                else if (I_BUSAKn) state_nxt_s = REQ;
                else               state_nxt_s = RD_DATA;
            end
            RD_DATA: begin
                if (!I_CE) begin
                    state_nxt_s = RD_DATA;
                end else if (I_BUSAKn) begin
                    state_nxt_s = REQ;
                end else begin
                    data_nxt_s  = I_SRC_D;
                    state_nxt_s = WR;
                end
            end
            WR: begin
                if (!I_CE) begin
                    state_nxt_s = WR;
                end else if (I_BUSAKn) begin
                    state_nxt_s = REQ;
                end else begin
                    n_nxt_s = n_r + 11'd1;
                    if (n_r == LAST_N) state_nxt_s = RELEASE;
                    else               state_nxt_s = RD_ADDR;
                end
            end
            RELEASE: begin
                if (I_CE) state_nxt_s = IDLE;
                else      state_nxt_s = RELEASE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Outputs decode the registered state; only the strobes depend on I_CE
    always_comb begin
        O_BUSY       = (state_r != IDLE);
        O_BUSRQn     = !((state_r == REQ) || (state_r == RD_ADDR) ||
                         (state_r == RD_DATA) || (state_r == WR));
        O_SRC_RDn    = !((state_r == RD_ADDR) || (state_r == RD_DATA));
        O_SRC_A      = src_addr(page_r, n_r);
        O_OBJ_DMA_A  = obj_addr(n_r);
        O_OBJ_DMA_D  = data_r;
        O_OBJ_DMA_CE = (state_r == WR) && I_CE && !I_BUSAKn;
        O_DONE       = (state_r == RELEASE) && I_CE;
    end

endmodule

// File: tb/tb_dkong3_obj_dma.sv
// Scoreboard bench for dkong3_obj_dma: expected object-RAM writes are queued at
// start time and popped by per-instance write monitors.
module tb_dkong3_obj_dma;

    logic        clk = 1'b0;
    logic        rst_n, ce, vblk, busak_n;
    logic        start_a, start_b;
    logic [7:0]  page;

    logic        busrq_a, rdn_a, obj_ce_a, busy_a, done_a;
    logic [15:0] src_a_a;
    logic [7:0]  src_d_a, obj_d_a;
    logic [9:0]  obj_a_a;

    logic        busrq_b, rdn_b, obj_ce_b, busy_b, done_b;
    logic [15:0] src_a_b;
    logic [7:0]  src_d_b, obj_d_b;
    logic [9:0]  obj_a_b;

    int vectors = 0;
    int miscompares = 0;
    int wr_cnt_a = 0, wr_cnt_b = 0, done_cnt_a = 0, done_cnt_b = 0;
    logic [17:0] exp_a[$];
    logic [17:0] exp_b[$];

    always #5 clk = ~clk;

    // Source memory model: contents depend on both address bytes
    function automatic logic [7:0] fsrc(input logic [15:0] a);
        return a[7:0] ^ {a[14:8], a[15]} ^ 8'hA5;
    endfunction

    assign src_d_a = fsrc(src_a_a);
    assign src_d_b = fsrc(src_a_b);

    dkong3_obj_dma dut_a (
        .I_CLK_24M(clk), .I_RSTn(rst_n), .I_CE(ce), .I_START(start_a),
        .I_SRC_PAGE(page), .I_VBLK(vblk), .O_BUSRQn(busrq_a), .I_BUSAKn(busak_n),
        .O_SRC_A(src_a_a), .O_SRC_RDn(rdn_a), .I_SRC_D(src_d_a),
        .O_OBJ_DMA_A(obj_a_a), .O_OBJ_DMA_D(obj_d_a), .O_OBJ_DMA_CE(obj_ce_a),
        .O_BUSY(busy_a), .O_DONE(done_a)
    );

    dkong3_obj_dma #(.XFER_LEN(1024), .OBJ_BASE(10'h200)) dut_b (
        .I_CLK_24M(clk), .I_RSTn(rst_n), .I_CE(ce), .I_START(start_b),
        .I_SRC_PAGE(page), .I_VBLK(vblk), .O_BUSRQn(busrq_b), .I_BUSAKn(busak_n),
        .O_SRC_A(src_a_b), .O_SRC_RDn(rdn_b), .I_SRC_D(src_d_b),
        .O_OBJ_DMA_A(obj_a_b), .O_OBJ_DMA_D(obj_d_b), .O_OBJ_DMA_CE(obj_ce_b),
        .O_BUSY(busy_b), .O_DONE(done_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_xfer(input bit to_b, input logic [7:0] pg, input int len, input logic [9:0] base);
        logic [15:0] sa;
        logic [9:0]  da;
        for (int i = 0; i < len; i++) begin
            sa = {pg, 8'h00} + 16'(i);
            da = base + 10'(i);
            if (to_b) exp_b.push_back({da, fsrc(sa)});
            else      exp_a.push_back({da, fsrc(sa)});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit to_b, input logic [7:0] pg);
        page = pg;
        if (to_b) start_b = 1'b1; else start_a = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_idle_a(input string name, input int limit);
        int g = 0;
        while (busy_a && g < limit) begin tick(); g++; end
        check(name, {31'd0, busy_a}, 32'd0);
    endtask

    task automatic wait_writes_a(input string name, input int target, input int limit);
        int g = 0;
        while (wr_cnt_a < target && g < limit) begin tick(); g++; end
        check(name, 32'(wr_cnt_a), 32'(target));
    endtask

    // Write monitor for the default instance
    always @(negedge clk) begin
        logic [17:0] e;
        if (obj_ce_a) begin
            wr_cnt_a++;
            vectors++;
            if (exp_a.size() == 0) begin
                miscompares++;
                $display("FAIL wr_a unexpected: got a=%03h d=%02h, none expected", obj_a_a, obj_d_a);
            end else begin
                e = exp_a.pop_front();
                if ({obj_a_a, obj_d_a} !== e) begin
                    miscompares++;
                    $display("FAIL wr_a: got a=%03h d=%02h expected a=%03h d=%02h",
                             obj_a_a, obj_d_a, e[17:8], e[7:0]);
                end
            end
        end
        if (done_a) done_cnt_a++;
    end

    // Write monitor for the wrap-around instance
    always @(negedge clk) begin
        logic [17:0] e;
        if (obj_ce_b) begin
            wr_cnt_b++;
            vectors++;
            if (exp_b.size() == 0) begin
                miscompares++;
                $display("FAIL wr_b unexpected: got a=%03h d=%02h, none expected", obj_a_b, obj_d_b);
            end else begin
                e = exp_b.pop_front();
                if ({obj_a_b, obj_d_b} !== e) begin
                    miscompares++;
                    $display("FAIL wr_b: got a=%03h d=%02h expected a=%03h d=%02h",
                             obj_a_b, obj_d_b, e[17:8], e[7:0]);
                end
            end
        end
        if (done_b) done_cnt_b++;
    end

    initial begin
        int g, cnt, base_w, base_d;
        logic [15:0] held_a;

        rst_n = 1'b0; ce = 1'b1; vblk = 1'b0; busak_n = 1'b1;
        start_a = 1'b0; start_b = 1'b0; page = 8'h00;
        #3;
        check("rst_busrq", {31'd0, busrq_a}, 32'd1);
        check("rst_rdn", {31'd0, rdn_a}, 32'd1);
        check("rst_src_a", {16'd0, src_a_a}, 32'h0);
        check("rst_obj_a_b", {22'd0, obj_a_b}, 32'h200);
        check("rst_obj_d", {24'd0, obj_d_a}, 32'h0);
        check("rst_ce_busy_done", {29'd0, obj_ce_a, busy_a, done_a}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Full transfer, late grant, ignored restart, CE freeze
        vblk = 1'b1;
        push_xfer(1'b0, 8'h60, 384, 10'h000);
        base_d = done_cnt_a;
        pulse_start(1'b0, 8'h60);
        check("busy_after_start", {31'd0, busy_a}, 32'd1);
        g = 0;
        while (busrq_a && g < 20) begin tick(); g++; end
        check("busrq_asserted", {31'd0, busrq_a}, 32'd0);
        repeat (2) tick();
        busak_n = 1'b0;
        wait_writes_a("reach_100", 100, 1000);
        pulse_start(1'b0, 8'h70);
        wait_writes_a("reach_150", 150, 1000);
        ce = 1'b0;
        held_a = src_a_a;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (obj_ce_a || src_a_a != held_a || busrq_a) cnt++;
        end
        tick();
        check("ce_freeze", 32'(cnt), 32'd0);
        ce = 1'b1;
        wait_idle_a("xfer1_end", 2000);
        check("xfer1_writes", 32'(wr_cnt_a), 32'd384);
        check("xfer1_queue", 32'(exp_a.size()), 32'd0);
        check("xfer1_done", 32'(done_cnt_a - base_d), 32'd1);
        check("xfer1_busrq_rel", {31'd0, busrq_a}, 32'd1);
        busak_n = 1'b1;

        // Start outside vblank, then grant drop during byte 10
        vblk = 1'b0;
        push_xfer(1'b0, 8'h60, 384, 10'h000);
        base_w = wr_cnt_a;
        base_d = done_cnt_a;
        pulse_start(1'b0, 8'h60);
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!busrq_a) cnt++;
        end
        check("no_req_before_vbl", 32'(cnt), 32'd0);
        vblk = 1'b1;
        tick();
        check("req_on_first_vbl", {31'd0, busrq_a}, 32'd0);
        vblk = 1'b0;
        busak_n = 1'b0;
        wait_writes_a("reach_10", base_w + 10, 200);
        busak_n = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("gap_no_write", 32'(wr_cnt_a - base_w), 32'd10);
        check("gap_still_req", {31'd0, busrq_a}, 32'd0);
        busak_n = 1'b0;
        g = 0;
        while (rdn_a && g < 10) begin tick(); g++; end
        check("reread_addr", {16'd0, src_a_a}, 32'h600A);
        wait_idle_a("xfer2_end", 2000);
        check("xfer2_writes", 32'(wr_cnt_a - base_w), 32'd384);
        check("xfer2_queue", 32'(exp_a.size()), 32'd0);
        check("xfer2_done", 32'(done_cnt_a - base_d), 32'd1);

        // Reset mid-transfer, then restart from N=0
        vblk = 1'b1;
        push_xfer(1'b0, 8'h60, 384, 10'h000);
        base_w = wr_cnt_a;
        pulse_start(1'b0, 8'h60);
        wait_writes_a("reach_200", base_w + 200, 1000);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busrq", {31'd0, busrq_a}, 32'd1);
        check("rst_mid_busy", {31'd0, busy_a}, 32'd0);
        check("rst_mid_ce", {31'd0, obj_ce_a}, 32'd0);
        exp_a.delete();
        base_w = wr_cnt_a;
        tick();
        check("rst_no_write", 32'(wr_cnt_a - base_w), 32'd0);
        rst_n = 1'b1;
        tick();
        push_xfer(1'b0, 8'h60, 384, 10'h000);
        base_w = wr_cnt_a;
        base_d = done_cnt_a;
        pulse_start(1'b0, 8'h60);
        g = 0;
        while (rdn_a && g < 10) begin tick(); g++; end
        check("restart_addr", {16'd0, src_a_a}, 32'h6000);
        wait_idle_a("xfer3_end", 2000);
        check("xfer3_writes", 32'(wr_cnt_a - base_w), 32'd384);
        check("xfer3_queue", 32'(exp_a.size()), 32'd0);
        check("xfer3_done", 32'(done_cnt_a - base_d), 32'd1);

        // Wrap-around instance: source and destination both wrap
        push_xfer(1'b1, 8'hFF, 1024, 10'h200);
        pulse_start(1'b1, 8'hFF);
        g = 0;
        while (busy_b && g < 4000) begin tick(); g++; end
        check("wrap_end", {31'd0, busy_b}, 32'd0);
        check("wrap_writes", 32'(wr_cnt_b), 32'd1024);
        check("wrap_queue", 32'(exp_b.size()), 32'd0);
        check("wrap_done", 32'(done_cnt_b), 32'd1);
        check("wrap_idle_a_writes", 32'(wr_cnt_a - base_w), 32'd384);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
